// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, widths, NOP word.
// No logic; types and constants only.
// Imported by the fetch top and its pipeline register.
package unidade_de_busca_pkg;

   localparam int LARGURA_END_PADRAO   = 26;
   localparam int LARGURA_INSTR_PADRAO = 32;
   localparam logic [31:0] NOP_PADRAO  = 32'h0;

   typedef enum logic [1:0] {
      OCIOSO   = 2'b00,
      BUSCA    = 2'b01,
      CHEIO    = 2'b10,
      DESCARTA = 2'b11
   } estado_t;

endpackage

// File: rtl/unidade_de_busca_registrador.sv
// Pipeline register holding {instruction, pc, valid}; used for IF/ID and for the skid buffer.
// Latency: one cycle from carrega/limpa to outputs.
// No backpressure of its own; the owner decides when to load or clear.
module registrador_if_id
   import unidade_de_busca_pkg::*;
#(
   parameter int                 LE  = LARGURA_END_PADRAO,
   parameter int                 LI  = LARGURA_INSTR_PADRAO,
   parameter logic [LI-1:0]      NOP = LI'(NOP_PADRAO)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          carrega,
   input  logic          limpa,
   input  logic [LI-1:0] instr_in,
   input  logic [LE-1:0] pc_in,
   output logic [LI-1:0] instr_out,
   output logic [LE-1:0] pc_out,
   output logic          valida_out
);

   logic [LI-1:0] instr_q, instr_d;
   logic [LE-1:0] pc_q, pc_d;
   logic          valida_q, valida_d;

   // Clear wins over load; a cleared entry shows NOP and keeps its last pc.
   always_comb begin
      instr_d  = instr_q;
      pc_d     = pc_q;
      valida_d = valida_q;
      if (limpa) begin
         instr_d  = NOP;
         valida_d = 1'b0;
      end else if (carrega) begin
         instr_d  = instr_in;
         pc_d     = pc_in;
         valida_d = 1'b1;
      end
   end

   // State register with synchronous reset to an empty NOP entry at pc 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q  <= NOP;
         pc_q     <= '0;
         valida_q <= 1'b0;
      end else begin
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         valida_q <= valida_d;
      end
   end

   assign instr_out  = instr_q;
   assign pc_out     = pc_q;
   assign valida_out = valida_q;

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch: reads memory at pcAtual, fills IF/ID plus a one-entry buffer, advances the PC.
// Latency: a word accepted in a cycle appears on instrucao the next cycle; 1 instr/cycle at zero wait.
// Backpressure: a busy decoder parks one word in the buffer and stops requesting until it drains.
module unidade_de_busca
   import unidade_de_busca_pkg::*;
#(
   parameter int                      LARGURA_END   = LARGURA_END_PADRAO,
   parameter int                      LARGURA_INSTR = LARGURA_INSTR_PADRAO,
   parameter logic [LARGURA_INSTR-1:0] NOP          = LARGURA_INSTR'(NOP_PADRAO)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [LARGURA_END-1:0]   pcAtual,
   output logic                     avanca_pc,
   output logic [LARGURA_END-1:0]   mem_endereco,
   output logic                     mem_req,
   input  logic                     mem_pronto,
   input  logic [LARGURA_INSTR-1:0] mem_dado,
   output logic [LARGURA_INSTR-1:0] instrucao,
   output logic [LARGURA_END-1:0]   pcInstrucao,
   output logic [LARGURA_END-1:0]   pcMais1,
   output logic                     instrucao_valida,
   input  logic                     decod_pronto,
   input  logic                     flush
);

   estado_t                  estado_q, estado_d;
   logic [LARGURA_END-1:0]   end_descarte_q, end_descarte_d;

   logic                     ifid_carrega, ifid_limpa, ifid_do_buffer;
   logic                     buf_carrega, buf_limpa, buf_valida;
   logic [LARGURA_INSTR-1:0] buf_instr, ifid_instr_in;
   logic [LARGURA_END-1:0]   buf_pc, ifid_pc_in;
   logic                     slot_livre, entrega;

   // The decoder frees the slot either because it is empty or because it takes it now.
   assign slot_livre = !instrucao_valida || decod_pronto;
   assign entrega    = instrucao_valida && decod_pronto;

   // While discarding, keep pointing at the killed request; pcAtual already holds the target.
   assign mem_endereco  = (estado_q == DESCARTA) ? end_descarte_q : pcAtual;
   assign pcMais1       = pcInstrucao + LARGURA_END'(1);
   assign ifid_instr_in = ifid_do_buffer ? buf_instr : mem_dado;
   assign ifid_pc_in    = ifid_do_buffer ? buf_pc    : pcAtual;

   // Next state and handshake controls; flush overrides every normal transition.
   always_comb begin
      estado_d       = estado_q;
      end_descarte_d = end_descarte_q;
      mem_req        = (estado_q == BUSCA) || (estado_q == DESCARTA);
      avanca_pc      = 1'b0;
      ifid_carrega   = 1'b0;
      ifid_limpa     = 1'b0;
      ifid_do_buffer = 1'b0;
      buf_carrega    = 1'b0;
      buf_limpa      = 1'b0;
      if (flush) begin
         ifid_limpa = 1'b1;
         buf_limpa  = 1'b1;
         case (estado_q)
            BUSCA: begin
               if (!mem_pronto) begin
                  estado_d       = DESCARTA;
                  end_descarte_d = pcAtual;
               end
            end
            DESCARTA: if (mem_pronto) estado_d = BUSCA;
            default:  estado_d = BUSCA;
         endcase
      end else begin
         case (estado_q)
            OCIOSO: begin
               estado_d   = BUSCA;
               ifid_limpa = entrega;
            end
            BUSCA: begin
               if (mem_pronto) begin
                  avanca_pc = 1'b1;
                  if (slot_livre) begin
                     ifid_carrega = 1'b1;
                  end else begin
                     buf_carrega = 1'b1;
                     estado_d    = CHEIO;
                  end
               end else begin
                  ifid_limpa = entrega;
               end
            end
            CHEIO: begin
               if (decod_pronto && buf_valida) begin
                  ifid_carrega   = 1'b1;
                  ifid_do_buffer = 1'b1;
                  buf_limpa      = 1'b1;
                  estado_d       = BUSCA;
               end
            end
            DESCARTA: begin
               ifid_limpa = entrega;
               if (mem_pronto) estado_d = BUSCA;
            end
            default: estado_d = OCIOSO;
         endcase
      end
   end

   // FSM state and killed-request address, synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q       <= OCIOSO;
         end_descarte_q <= '0;
      end else begin
         estado_q       <= estado_d;
         end_descarte_q <= end_descarte_d;
      end
   end

   registrador_if_id #(.LE(LARGURA_END), .LI(LARGURA_INSTR), .NOP(NOP)) u_if_id (
      .clock      (clock),
      .reset      (reset),
      .carrega    (ifid_carrega),
      .limpa      (ifid_limpa),
      .instr_in   (ifid_instr_in),
      .pc_in      (ifid_pc_in),
      .instr_out  (instrucao),
      .pc_out     (pcInstrucao),
      .valida_out (instrucao_valida)
   );

   registrador_if_id #(.LE(LARGURA_END), .LI(LARGURA_INSTR), .NOP(NOP)) u_buffer (
      .clock      (clock),
      .reset      (reset),
      .carrega    (buf_carrega),
      .limpa      (buf_limpa),
      .instr_in   (mem_dado),
      .pc_in      (pcAtual),
      .instr_out  (buf_instr),
      .pc_out     (buf_pc),
      .valida_out (buf_valida)
   );

endmodule
